// File: rtl/sensor_pkg.sv
// Shared constants and helpers for the sensor arbiter slice.
package sensor_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int DROP_CNT_WIDTH     = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after `last`, wrapping N-1 -> 0.
module rr_arbiter
    import sensor_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0]        request,
    input  logic [clog2(N)-1:0] last,
    output logic                grant_valid,
    output logic [clog2(N)-1:0] grant_idx
);

    localparam int IW = clog2(N);

    logic [IW-1:0] w_idx;

    // Scan from lowest to highest priority so the nearest requester after `last` is kept.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = '0;
        for (int off = N; off >= 1; off--) begin
            w_idx = IW'((int'(last) + off) % N);
            if (request[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/sensor_arbiter.sv
// Per-channel single-entry sample slots, round-robin drain into a registered
// valid/ready output stage, with sticky overflow flags and a saturating drop counter.
module sensor_arbiter
    import sensor_pkg::*;
#(
    parameter int NUM_SENSORS = 9,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int ID_WIDTH    = clog2(NUM_SENSORS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_value,
    input  logic [NUM_SENSORS-1:0]            data_available,
    output logic [DATA_WIDTH-1:0]             sensor_value_out,
    output logic [ID_WIDTH-1:0]               sensor_id_out,
    output logic                              write,
    input  logic                              ready,
    output logic [NUM_SENSORS-1:0]            overflow,
    output logic [DROP_CNT_WIDTH-1:0]         dropped_count
);

    localparam int IDX_W     = clog2(NUM_SENSORS);
    localparam int CNT_SUM_W = DROP_CNT_WIDTH + 1;

    logic [DATA_WIDTH-1:0]     r_value [NUM_SENSORS];
    logic [NUM_SENSORS-1:0]    r_pending;
    logic [NUM_SENSORS-1:0]    r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_count;
    logic [IDX_W-1:0]          r_last;
    logic                      r_write;
    logic [DATA_WIDTH-1:0]     r_value_out;
    logic [ID_WIDTH-1:0]       r_id_out;

    logic                      w_grant_valid;
    logic [IDX_W-1:0]          w_grant_idx;
    logic                      w_load;
    logic [NUM_SENSORS-1:0]    w_grant_oh;
    logic [NUM_SENSORS-1:0]    w_capture;
    logic [NUM_SENSORS-1:0]    w_drop;
    logic [CNT_SUM_W-1:0]      w_drop_num;
    logic [CNT_SUM_W-1:0]      w_cnt_sum;
    logic [DROP_CNT_WIDTH-1:0] w_count_d;

    rr_arbiter #(
        .N (NUM_SENSORS)
    ) u_rr_arbiter (
        .request     (r_pending),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // A slot being granted this edge is free to take a new strobe at the same edge.
    always_comb begin
        w_load     = w_grant_valid & (~r_write | ready);
        w_grant_oh = w_load ? (NUM_SENSORS'(1) << w_grant_idx) : '0;
        w_capture  = data_available & (~r_pending | w_grant_oh);
        w_drop     = data_available & r_pending & ~w_grant_oh;
        w_drop_num = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_drop_num = w_drop_num + CNT_SUM_W'(w_drop[i]);
        end
        w_cnt_sum = {1'b0, r_count} + w_drop_num;
        w_count_d = w_cnt_sum[DROP_CNT_WIDTH] ? '1 : w_cnt_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (w_capture[i]) begin
                    r_value[i] <= sensor_value[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_overflow  <= '0;
            r_count     <= '0;
            r_last      <= IDX_W'(NUM_SENSORS - 1);
            r_write     <= 1'b0;
            r_value_out <= '0;
            r_id_out    <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_grant_oh) | w_capture;
            r_overflow <= r_overflow | w_drop;
            r_count    <= w_count_d;
            if (w_load) begin
                r_write     <= 1'b1;
                r_value_out <= r_value[w_grant_idx];
                r_id_out    <= ID_WIDTH'(w_grant_idx);
                r_last      <= w_grant_idx;
            end else if (ready) begin
                r_write <= 1'b0;
            end
        end
    end

    assign write            = r_write;
    assign sensor_value_out = r_value_out;
    assign sensor_id_out    = r_id_out;
    assign overflow         = r_overflow;
    assign dropped_count    = r_count;

endmodule

// File: tb/tb_sensor_arbiter.sv
// Bench for sensor_arbiter: directed tables and sequences plus random traffic against a model.
module tb_sensor_arbiter;

    localparam int N  = 9;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk;
    logic              reset;
    logic [N*DW-1:0]   sensor_value;
    logic [N-1:0]      data_available;
    logic [DW-1:0]     sensor_value_out;
    logic [IW-1:0]     sensor_id_out;
    logic              write;
    logic              ready;
    logic [N-1:0]      overflow;
    logic [15:0]       dropped_count;

    sensor_arbiter #(
        .NUM_SENSORS (N),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_value     (sensor_value),
        .data_available   (data_available),
        .sensor_value_out (sensor_value_out),
        .sensor_id_out    (sensor_id_out),
        .write            (write),
        .ready            (ready),
        .overflow         (overflow),
        .dropped_count    (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] val;
    } xfer_t;
    xfer_t log_q[$];

    typedef struct {
        int            ch;
        logic [DW-1:0] val;
        int            exp_id;
        logic [DW-1:0] exp_val;
    } vec_t;
    vec_t vecs[6];

    // Reference model: slots as a bit/value per channel, output as a one-deep holding spot.
    bit            m_pend [N];
    logic [DW-1:0] m_val  [N];
    bit            m_wr;
    logic [DW-1:0] m_oval;
    int            m_oid;
    int            m_last;
    bit [N-1:0]    m_ovf;
    int            m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] av, input logic [N*DW-1:0] sv,
                              input logic rdy, input logic rs);
        int g;
        if (rs) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_wr = 0; m_oval = '0; m_oid = 0; m_last = N - 1; m_ovf = '0; m_cnt = 0;
        end else begin
            g = -1;
            if (!m_wr || rdy) begin
                for (int off = 1; off <= N && g < 0; off++) begin
                    if (m_pend[(m_last + off) % N]) g = (m_last + off) % N;
                end
            end
            if (g >= 0) begin
                m_wr = 1; m_oval = m_val[g]; m_oid = g; m_last = g; m_pend[g] = 0;
            end else if (rdy) begin
                m_wr = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (av[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1;
                        m_val[i]  = sv[i*DW +: DW];
                    end else begin
                        m_ovf[i] = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, log any handshake, step the model, compare after the edge.
    task automatic cycle(input logic [N-1:0] av, input logic [N*DW-1:0] sv,
                         input logic rdy, input logic rs);
        @(negedge clk);
        data_available = av;
        sensor_value   = sv;
        ready          = rdy;
        reset          = rs;
        if (write && rdy && !rs) log_q.push_back('{int'(sensor_id_out), sensor_value_out});
        model_step(av, sv, rdy, rs);
        @(posedge clk);
        #1;
        check("model write", 64'(write), 64'(m_wr));
        if (m_wr) begin
            check("model id", 64'(sensor_id_out), 64'(m_oid));
            check("model value", 64'(sensor_value_out), 64'(m_oval));
        end
        check("model overflow", 64'(overflow), 64'(m_ovf));
        check("model dropped_count", 64'(dropped_count), 64'(m_cnt));
    endtask

    task automatic idle(input logic rdy);
        cycle('0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cycle('0, '0, 1'b0, 1'b1);
        log_q.delete();
    endtask

    function automatic logic [N*DW-1:0] put(input logic [N*DW-1:0] bus, input int ch,
                                            input logic [DW-1:0] v);
        bus[ch*DW +: DW] = v;
        return bus;
    endfunction

    function automatic logic [N-1:0] bit_of(input int ch);
        logic [N-1:0] one;
        one = 1;
        return one << ch;
    endfunction

    initial begin
        logic [N*DW-1:0] sv;
        logic [N-1:0]    av;
        reset = 1'b1; ready = 1'b0; data_available = '0; sensor_value = '0;

        // Reset state.
        cycle('0, '0, 1'b0, 1'b1);
        cycle('1, '1, 1'b1, 1'b1);
        check("reset write", 64'(write), 64'(0));
        check("reset value", 64'(sensor_value_out), 64'(0));
        check("reset id", 64'(sensor_id_out), 64'(0));
        check("reset overflow", 64'(overflow), 64'(0));
        check("reset count", 64'(dropped_count), 64'(0));

        // Single strobes: write rises two edges after the strobe, for exactly one cycle.
        vecs[0] = '{3, 32'hDEAD_0003, 3, 32'hDEAD_0003};
        vecs[1] = '{0, 32'h0000_0000, 0, 32'h0000_0000};
        vecs[2] = '{8, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFF};
        vecs[3] = '{1, 32'h1234_5678, 1, 32'h1234_5678};
        vecs[4] = '{7, 32'hA5A5_5A5A, 7, 32'hA5A5_5A5A};
        vecs[5] = '{4, 32'h8000_0001, 4, 32'h8000_0001};
        do_reset();
        for (int v = 0; v < 6; v++) begin
            cycle(bit_of(vecs[v].ch), put('0, vecs[v].ch, vecs[v].val), 1'b1, 1'b0);
            check("single early", 64'(write), 64'(0));
            idle(1'b1);
            check("single write", 64'(write), 64'(1));
            check("single id", 64'(sensor_id_out), 64'(vecs[v].exp_id));
            check("single value", 64'(sensor_value_out), 64'(vecs[v].exp_val));
            idle(1'b1);
            check("single pulse", 64'(write), 64'(0));
        end

        // Simultaneous strobes on 0, 4, 8.
        do_reset();
        sv = put(put(put('0, 0, 32'hC0), 4, 32'hC4), 8, 32'hC8);
        cycle(bit_of(0) | bit_of(4) | bit_of(8), sv, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("simul count", 64'(log_q.size()), 64'(3));
        if (log_q.size() >= 3) begin
            check("simul id0", 64'(log_q[0].id), 64'(0));
            check("simul id1", 64'(log_q[1].id), 64'(4));
            check("simul id2", 64'(log_q[2].id), 64'(8));
            check("simul val2", 64'(log_q[2].val), 64'(32'hC8));
        end
        check("simul drops", 64'(dropped_count), 64'(0));

        // Backpressure on ch1 with ch2 queued behind it.
        do_reset();
        sv = put(put('0, 1, 32'h1111_0001), 2, 32'h2222_0002);
        cycle(bit_of(1) | bit_of(2), sv, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            check("bp write", 64'(write), 64'(1));
            check("bp id", 64'(sensor_id_out), 64'(1));
            check("bp value", 64'(sensor_value_out), 64'(32'h1111_0001));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("bp count", 64'(log_q.size()), 64'(2));
        if (log_q.size() >= 2) begin
            check("bp first", 64'(log_q[0].id), 64'(1));
            check("bp second", 64'(log_q[1].id), 64'(2));
            check("bp second val", 64'(log_q[1].val), 64'(32'h2222_0002));
        end

        // Overflow: output stage held by ch0, then ch5 strobed twice.
        do_reset();
        cycle(bit_of(0), put('0, 0, 32'hAAAA_0000), 1'b0, 1'b0);
        idle(1'b0);
        cycle(bit_of(5), put('0, 5, 32'h1), 1'b0, 1'b0);
        cycle(bit_of(5), put('0, 5, 32'h2), 1'b0, 1'b0);
        idle(1'b0);
        check("ovf flags", 64'(overflow), 64'(9'h020));
        check("ovf count", 64'(dropped_count), 64'(1));
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("ovf xfers", 64'(log_q.size()), 64'(2));
        if (log_q.size() >= 2) begin
            check("ovf ch5 id", 64'(log_q[1].id), 64'(5));
            check("ovf ch5 val", 64'(log_q[1].val), 64'(32'h1));
        end
        check("ovf sticky", 64'(overflow), 64'(9'h020));

        // Fairness: every channel strobed every cycle.
        do_reset();
        for (int c = 0; c < 27; c++) begin
            sv = '0;
            for (int ch = 0; ch < N; ch++) sv = put(sv, ch, (c << 8) | ch);
            cycle('1, sv, 1'b1, 1'b0);
        end
        for (int i = 0; i < 15 && log_q.size() < 27; i++) idle(1'b1);
        check("fair count", 64'(log_q.size() >= 27), 64'(1));
        for (int i = 0; i < 27 && i < log_q.size(); i++) begin
            check("fair rotation", 64'(log_q[i].id), 64'(i % N));
        end

        // Reset mid-operation.
        do_reset();
        sv = '0;
        for (int ch = 0; ch < 4; ch++) sv = put(sv, ch, 32'h5000 + ch);
        cycle(4'hF, sv, 1'b0, 1'b0);
        cycle(bit_of(1), put('0, 1, 32'h5555), 1'b0, 1'b0);
        check("mid write", 64'(write), 64'(1));
        check("mid ovf", 64'(overflow), 64'(9'h002));
        cycle('0, '0, 1'b1, 1'b1);
        check("mid rst write", 64'(write), 64'(0));
        check("mid rst ovf", 64'(overflow), 64'(0));
        check("mid rst count", 64'(dropped_count), 64'(0));
        log_q.delete();
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("mid no stale", 64'(log_q.size()), 64'(0));

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            av = '0;
            sv = '0;
            for (int ch = 0; ch < N; ch++) begin
                av[ch] = ($urandom_range(0, 3) == 0);
                sv = put(sv, ch, $urandom);
            end
            cycle(av, sv, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end

        // Drop counter saturation.
        do_reset();
        for (int c = 0; c < 7300; c++) cycle('1, '0, 1'b0, 1'b0);
        check("sat count", 64'(dropped_count), 64'(16'hFFFF));
        check("sat ovf", 64'(overflow), 64'(9'h1FF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/sensor_arbiter.md
SENSOR_ARBITER -- requirements
Module: sensor_arbiter

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 9: number of sensor channels, legal range 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of each sensor value.
REQ-003 SHALL have parameter ID_WIDTH, default clog2(NUM_SENSORS): width of the channel index.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port sensor_value, input, NUM_SENSORS*DATA_WIDTH: flat bus; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port data_available, input, NUM_SENSORS: per-channel 1-cycle strobe qualifying sensor_value; any number of bits may be high at once.
REQ-008 SHALL have port sensor_value_out, output, DATA_WIDTH: value of the selected sample.
REQ-009 SHALL have port sensor_id_out, output, ID_WIDTH: channel index of sensor_value_out.
REQ-010 SHALL have port write, output, 1: output-valid.
REQ-011 SHALL have port ready, input, 1: downstream accept; a transfer occurs when write and ready are both high.
REQ-012 SHALL have port overflow, output, NUM_SENSORS: sticky per-channel sample-dropped flags.
REQ-013 SHALL have port dropped_count, output, 16: saturating count of dropped samples.

Function
REQ-014 SHALL hold one pending slot per channel (value register plus pending bit).
REQ-015 SHALL capture data_available[i] at edge k only if the slot is free, or is being granted at edge k; this sets pending[i] after edge k.
REQ-016 SHALL, on a strobe to an occupied slot that is not being granted, keep the old value, set overflow[i], and increment dropped_count.
REQ-017 SHALL increment dropped_count once per dropped sample; for multiple channels dropping in one cycle it increments by their popcount; it saturates at 16'hFFFF.
REQ-018 SHALL use a registered output stage: write, sensor_value_out and sensor_id_out are all flops.
REQ-019 SHALL load the output stage at an edge when it is empty or accepting (write && ready) and any pending bit is set.
REQ-020 SHALL clear the granted pending bit at the load edge.
REQ-021 SHALL arbitrate round-robin: search starts at the channel after the last granted one, wrapping NUM_SENSORS-1 to 0; after reset the last-granted index is NUM_SENSORS-1, so channel 0 wins first.
REQ-022 SHALL, while write && !ready, hold sensor_value_out and sensor_id_out stable and keep write high.
REQ-023 SHALL clear write at an accepting edge when nothing is pending.
REQ-024 SHALL have minimum latency of 1 edge from strobe capture to write: strobe sampled at edge k gives write high after edge k+1.
REQ-025 SHALL sustain a throughput of one transfer per clock while ready is held high.
REQ-026 SHALL set overflow bits sticky; they clear only on reset.

Reset
REQ-027 SHALL, with reset high at an edge, clear write, sensor_value_out, sensor_id_out, all pending bits, overflow, and dropped_count, and set last-granted to NUM_SENSORS-1.
REQ-028 SHALL, on reset mid-operation, discard pending samples and any held output, with write low after that edge regardless of ready.
REQ-029 SHALL ignore strobes in a reset cycle.

Structure
REQ-030 SHALL place DATA_WIDTH_DEFAULT, DROP_CNT_WIDTH (16) and the clog2 helper function in shared package sensor_pkg.
REQ-031 SHALL implement round-robin selection in sub-module rr_arbiter, parameter N, with inputs request[N-1:0], last[clog2 N-1:0], and outputs grant_valid and grant_idx, purely combinational.
REQ-032 SHALL keep the slots, output stage and counters in sensor_arbiter.

Verification
REQ-033 SHALL cover single strobe: ch3 value 32'hDEAD_0003, ready=1 -> write high exactly one cycle, 2 edges after the strobe, id=3, value matches.
REQ-034 SHALL cover simultaneous strobes: ch0, ch4 and ch8 in one cycle, ready=1 -> three consecutive writes with ids 0, 4, 8, and no drops.
REQ-035 SHALL cover backpressure: ready=0 for 10 cycles with ch1 and ch2 strobed once -> ch1 held stable, write high throughout; ready=1 -> ch1 then ch2 delivered.
REQ-036 SHALL cover overflow: ready=0, ch5 strobed with 32'h1 then 32'h2 -> overflow[5]=1, dropped_count=1, and 32'h1 delivered after ready=1.
REQ-037 SHALL cover fairness: all channels strobed every cycle, ready=1 for 27 cycles -> each id delivered 3 times in strict rotation 0..8.
REQ-038 SHALL cover reset mid-operation: 4 pending and write high, reset for 1 cycle -> write low next cycle, overflow=0, count=0, no stale sample delivered later.
